// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the receive path (and reusable by the
// transmit path).
//   rx_state_t      : receiver FSM states IDLE / START / DATA / STOP
//   FRAME_DATA_BITS : number of data bits in one 8N1 frame
//   STOP_LEVEL      : line level of a valid stop bit
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int   FRAME_DATA_BITS = 8;
    localparam logic STOP_LEVEL      = 1'b1;

endpackage : uart_pkg

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO. The head entry is always visible on dout;
// a pop advances to the next entry, visible the cycle after the pop.
// Pointers carry one extra wrap bit so full and empty can be told apart
// without a separate occupancy counter.
//   clk   in   clock, rising edge
//   rst   in   synchronous active-low reset; empties the FIFO
//   push  in   write din; ignored when full unless a pop frees a slot
//   pop   in   drop head entry; ignored when empty
//   din   in   WIDTH-bit write data
//   dout  out  WIDTH-bit head entry (undefined content when empty)
//   empty out  no entries stored
//   full  out  DEPTH entries stored
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);

    // A pop in the same cycle frees the head slot, so a push into a full
    // FIFO is still accepted when accompanied by a real pop.
    assign w_do_pop  = pop && !w_empty;
    assign w_do_push = push && (!w_full || w_do_pop);

    assign empty = w_empty;
    assign full  = w_full;
    assign dout  = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update. The extra MSB toggles on every wrap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage has no reset; stale content is never exposed while empty.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule : sync_fifo

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// 8N1 UART receiver with a receive FIFO and sticky error flags.
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-low reset
//   rx        in   asynchronous serial input, idle high
//   rd_en     in   pop head byte; ignored when empty
//   clr_err   in   clear frame_err and overrun (a same-cycle set wins)
//   rx_data   out  head byte (show-ahead), 0 when empty
//   rx_valid  out  FIFO not empty
//   Rxff      out  FIFO full
//   frame_err out  sticky: a frame had a low stop bit
//   overrun   out  sticky: a good byte was dropped on a full FIFO
//   rx_busy   out  receiver is not in IDLE
// ---------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_DIV = 16,
    parameter int DEPTH   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd_en,
    input  logic       clr_err,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       Rxff,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);

    localparam int             CW       = $clog2(CLK_DIV);
    localparam logic [CW-1:0]  HALF_M1  = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0]  FULL_M1  = CW'(CLK_DIV - 1);
    localparam logic [2:0]     LAST_BIT = 3'(FRAME_DATA_BITS - 1);

    logic                       r_sync1;
    logic                       r_sync2;
    rx_state_t                  r_state;
    logic [CW-1:0]              r_tick_cnt;
    logic [2:0]                 r_bit_cnt;
    logic [FRAME_DATA_BITS-1:0] r_shift;
    logic                       r_break_wait;
    logic                       r_busy;
    logic                       r_frame_err;
    logic                       r_overrun;

    logic       w_rxs;
    logic       w_stop_sample;
    logic       w_stop_ok;
    logic       w_stop_bad;
    logic       w_pop;
    logic       w_push;
    logic       w_overrun_set;
    logic [7:0] w_dout;
    logic       w_empty;
    logic       w_full;

    // Two-flop synchroniser on the asynchronous line. Both flops reset to
    // the idle level so reset release never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxs = r_sync2;

    // Receiver FSM. The tick counter times half a bit in START (to reach the
    // start-bit centre) and whole bits afterwards, so every sample lands at a
    // bit centre. Data arrives LSB first and is shifted in at the top. After
    // a low stop bit the FSM parks in STOP until the line goes high again,
    // so a break condition is not mistaken for a stream of start bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_tick_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_break_wait <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_rxs) begin
                        r_state    <= START;
                        r_tick_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                START: begin
                    if (r_tick_cnt == HALF_M1) begin
                        r_tick_cnt <= '0;
                        if (!w_rxs) begin
                            r_state   <= DATA;
                            r_bit_cnt <= '0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_tick_cnt <= r_tick_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (r_tick_cnt == FULL_M1) begin
                        r_tick_cnt <= '0;
                        r_shift    <= {w_rxs, r_shift[FRAME_DATA_BITS-1:1]};
                        if (r_bit_cnt == LAST_BIT) begin
                            r_state   <= STOP;
                            r_bit_cnt <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end else begin
                        r_tick_cnt <= r_tick_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (r_break_wait) begin
                        if (w_rxs) begin
                            r_break_wait <= 1'b0;
                            r_state      <= IDLE;
                            r_busy       <= 1'b0;
                        end
                    end else if (r_tick_cnt == FULL_M1) begin
                        r_tick_cnt <= '0;
                        if (w_rxs == STOP_LEVEL) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_break_wait <= 1'b1;
                        end
                    end else begin
                        r_tick_cnt <= r_tick_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Stop-bit sample decode. A push into a full FIFO still succeeds when
    // the same cycle pops the head; only otherwise is the byte lost.
    assign w_stop_sample = (r_state == STOP) && !r_break_wait && (r_tick_cnt == FULL_M1);
    assign w_stop_ok     = w_stop_sample && (w_rxs == STOP_LEVEL);
    assign w_stop_bad    = w_stop_sample && (w_rxs != STOP_LEVEL);
    assign w_pop         = rd_en && !w_empty;
    assign w_push        = w_stop_ok && (!w_full || w_pop);
    assign w_overrun_set = w_stop_ok && w_full && !w_pop;

    // Sticky error flags. A set event in the same cycle as clr_err wins so
    // software never loses an error that happened while it was clearing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_stop_bad) begin
                r_frame_err <= 1'b1;
            end else if (clr_err) begin
                r_frame_err <= 1'b0;
            end
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (clr_err) begin
                r_overrun <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (r_shift),
        .dout  (w_dout),
        .empty (w_empty),
        .full  (w_full)
    );

    assign rx_data   = w_empty ? 8'h00 : w_dout;
    assign rx_valid  = !w_empty;
    assign Rxff      = w_full;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign rx_busy   = r_busy;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Directed bench for uart_rx_fifo at CLK_DIV = 16, DEPTH = 8. Serial bits are
// driven on falling clock edges and outputs are observed on falling edges.
// With the start bit driven at falling edge 0, the stop-bit sample happens
// at rising edge 155, so a pushed byte is first seen at falling edge 155.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       Rxff;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;

    int errors = 0;
    int checks = 0;
    int riseAt;

    uart_rx_fifo #(
        .CLK_DIV (16),
        .DEPTH   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rd_en     (rd_en),
        .clr_err   (clr_err),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .Rxff      (Rxff),
        .frame_err (frame_err),
        .overrun   (overrun),
        .rx_busy   (rx_busy)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one 160-clock frame starting at the next falling edge. rd_en and
    // clr_err pulse for one cycle at the given index (-1 for none). riseAt
    // records the first falling edge at which rx_valid goes 0 -> 1.
    task automatic sendFrame(input logic [7:0] data, input logic stopBit,
                             input int popAt, input int clrAt);
        logic [9:0] cur;
        logic       prevValid;
        cur       = {stopBit, data, 1'b0};
        riseAt    = -1;
        prevValid = rx_valid;
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            if (i > 0 && rx_valid && !prevValid && riseAt < 0) riseAt = i;
            prevValid = rx_valid;
            rx      = cur[0];
            rd_en   = (i == popAt);
            clr_err = (i == clrAt);
            if ((i % 16) == 15) cur = {1'b1, cur[9:1]};
        end
    endtask

    task automatic popOne();
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic pulseClr();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (rx_valid !== 1'b0)   begin errors++; $display("[TB] FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        checks++; if (Rxff !== 1'b0)       begin errors++; $display("[TB] FAIL reset_Rxff: got %b expected 0", Rxff); end
        checks++; if (frame_err !== 1'b0)  begin errors++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++; if (overrun !== 1'b0)    begin errors++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
        checks++; if (rx_busy !== 1'b0)    begin errors++; $display("[TB] FAIL reset_rx_busy: got %b expected 0", rx_busy); end
        checks++; if (rx_data !== 8'h00)   begin errors++; $display("[TB] FAIL reset_rx_data: got %h expected 00", rx_data); end
        rst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single_frame();
        sendFrame(8'hA5, 1'b1, -1, -1);
        checks++; if (riseAt !== 155)      begin errors++; $display("[TB] FAIL single_rise_cycle: got %0d expected 155", riseAt); end
        checks++; if (rx_valid !== 1'b1)   begin errors++; $display("[TB] FAIL single_valid: got %b expected 1", rx_valid); end
        checks++; if (rx_data !== 8'hA5)   begin errors++; $display("[TB] FAIL single_data: got %h expected a5", rx_data); end
        checks++; if (frame_err !== 1'b0)  begin errors++; $display("[TB] FAIL single_frame_err: got %b expected 0", frame_err); end
        popOne();
        checks++; if (rx_valid !== 1'b0)   begin errors++; $display("[TB] FAIL single_pop_valid: got %b expected 0", rx_valid); end
        checks++; if (rx_data !== 8'h00)   begin errors++; $display("[TB] FAIL single_pop_data: got %h expected 00", rx_data); end
    endtask

    task automatic test_glitch();
        logic sawBusy;
        sawBusy = 1'b0;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            if (rx_busy) sawBusy = 1'b1;
            rx = (i < 6) ? 1'b0 : 1'b1;
        end
        checks++; if (sawBusy !== 1'b1)    begin errors++; $display("[TB] FAIL glitch_start_seen: got %b expected 1", sawBusy); end
        checks++; if (rx_busy !== 1'b0)    begin errors++; $display("[TB] FAIL glitch_back_idle: got %b expected 0", rx_busy); end
        checks++; if (rx_valid !== 1'b0)   begin errors++; $display("[TB] FAIL glitch_valid: got %b expected 0", rx_valid); end
        checks++; if (frame_err !== 1'b0)  begin errors++; $display("[TB] FAIL glitch_frame_err: got %b expected 0", frame_err); end
        checks++; if (overrun !== 1'b0)    begin errors++; $display("[TB] FAIL glitch_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_frame_error();
        sendFrame(8'h3C, 1'b0, -1, -1);
        checks++; if (frame_err !== 1'b1)  begin errors++; $display("[TB] FAIL ferr_set: got %b expected 1", frame_err); end
        checks++; if (rx_valid !== 1'b0)   begin errors++; $display("[TB] FAIL ferr_no_push: got %b expected 0", rx_valid); end
        repeat (20) @(negedge clk);
        checks++; if (rx_busy !== 1'b1)    begin errors++; $display("[TB] FAIL ferr_break_wait: got %b expected 1", rx_busy); end
        rx = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (rx_busy !== 1'b0)    begin errors++; $display("[TB] FAIL ferr_idle_after_high: got %b expected 0", rx_busy); end
        sendFrame(8'h55, 1'b1, -1, -1);
        checks++; if (rx_data !== 8'h55)   begin errors++; $display("[TB] FAIL ferr_next_data: got %h expected 55", rx_data); end
        checks++; if (riseAt !== 155)      begin errors++; $display("[TB] FAIL ferr_next_rise: got %0d expected 155", riseAt); end
        checks++; if (frame_err !== 1'b1)  begin errors++; $display("[TB] FAIL ferr_still_sticky: got %b expected 1", frame_err); end
        pulseClr();
        checks++; if (frame_err !== 1'b0)  begin errors++; $display("[TB] FAIL ferr_clear: got %b expected 0", frame_err); end
        popOne();
        // Bad stop bit with clr_err in the very same cycle: the set must win.
        sendFrame(8'h81, 1'b0, -1, 154);
        checks++; if (frame_err !== 1'b1)  begin errors++; $display("[TB] FAIL ferr_set_wins: got %b expected 1", frame_err); end
        rx = 1'b1;
        repeat (5) @(negedge clk);
        pulseClr();
        checks++; if (frame_err !== 1'b0)  begin errors++; $display("[TB] FAIL ferr_clear2: got %b expected 0", frame_err); end
        checks++; if (rx_valid !== 1'b0)   begin errors++; $display("[TB] FAIL ferr_empty: got %b expected 0", rx_valid); end
    endtask

    task automatic test_overrun();
        for (int k = 0; k < 9; k++) begin
            sendFrame(8'(k), 1'b1, -1, -1);
            if (k == 6) begin
                checks++; if (Rxff !== 1'b0) begin errors++; $display("[TB] FAIL ovr_not_full_at7: got %b expected 0", Rxff); end
            end
            if (k == 7) begin
                checks++; if (Rxff !== 1'b1)    begin errors++; $display("[TB] FAIL ovr_full_at8: got %b expected 1", Rxff); end
                checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL ovr_none_at8: got %b expected 0", overrun); end
            end
        end
        checks++; if (overrun !== 1'b1)    begin errors++; $display("[TB] FAIL ovr_set: got %b expected 1", overrun); end
        checks++; if (frame_err !== 1'b0)  begin errors++; $display("[TB] FAIL ovr_frame_err: got %b expected 0", frame_err); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (rx_data !== 8'(k)) begin errors++; $display("[TB] FAIL ovr_read_%0d: got %h expected %h", k, rx_data, 8'(k)); end
            popOne();
        end
        checks++; if (rx_valid !== 1'b0)   begin errors++; $display("[TB] FAIL ovr_drained: got %b expected 0", rx_valid); end
        checks++; if (Rxff !== 1'b0)       begin errors++; $display("[TB] FAIL ovr_not_full: got %b expected 0", Rxff); end
        pulseClr();
        checks++; if (overrun !== 1'b0)    begin errors++; $display("[TB] FAIL ovr_clear: got %b expected 0", overrun); end
    endtask

    task automatic test_full_pop();
        for (int k = 0; k < 8; k++) sendFrame(8'(k), 1'b1, -1, -1);
        checks++; if (Rxff !== 1'b1)       begin errors++; $display("[TB] FAIL fpop_full: got %b expected 1", Rxff); end
        // rd_en high in the cycle of the 9th push.
        sendFrame(8'h08, 1'b1, 154, -1);
        checks++; if (overrun !== 1'b0)    begin errors++; $display("[TB] FAIL fpop_overrun: got %b expected 0", overrun); end
        checks++; if (Rxff !== 1'b1)       begin errors++; $display("[TB] FAIL fpop_still_full: got %b expected 1", Rxff); end
        for (int k = 1; k < 9; k++) begin
            checks++; if (rx_data !== 8'(k)) begin errors++; $display("[TB] FAIL fpop_read_%0d: got %h expected %h", k, rx_data, 8'(k)); end
            popOne();
        end
        checks++; if (rx_valid !== 1'b0)   begin errors++; $display("[TB] FAIL fpop_drained: got %b expected 0", rx_valid); end
    endtask

    task automatic test_back_to_back();
        sendFrame(8'h96, 1'b1, -1, -1);
        sendFrame(8'h3F, 1'b1, -1, -1);
        checks++; if (riseAt !== -1)       begin errors++; $display("[TB] FAIL b2b_no_new_rise: got %0d expected -1", riseAt); end
        checks++; if (rx_data !== 8'h96)   begin errors++; $display("[TB] FAIL b2b_first: got %h expected 96", rx_data); end
        popOne();
        checks++; if (rx_data !== 8'h3F)   begin errors++; $display("[TB] FAIL b2b_second: got %h expected 3f", rx_data); end
        popOne();
        checks++; if (rx_valid !== 1'b0)   begin errors++; $display("[TB] FAIL b2b_drained: got %b expected 0", rx_valid); end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] cur;
        sendFrame(8'h11, 1'b1, -1, -1);
        checks++; if (rx_valid !== 1'b1)   begin errors++; $display("[TB] FAIL rmid_pre_valid: got %b expected 1", rx_valid); end
        // Start bit plus four data bits of 0xA5, then reset.
        cur = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            rx = cur[0];
            if ((i % 16) == 15) cur = {1'b1, cur[9:1]};
        end
        checks++; if (rx_busy !== 1'b1)    begin errors++; $display("[TB] FAIL rmid_busy: got %b expected 1", rx_busy); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (rx_valid !== 1'b0)   begin errors++; $display("[TB] FAIL rmid_rx_valid: got %b expected 0", rx_valid); end
        checks++; if (Rxff !== 1'b0)       begin errors++; $display("[TB] FAIL rmid_Rxff: got %b expected 0", Rxff); end
        checks++; if (frame_err !== 1'b0)  begin errors++; $display("[TB] FAIL rmid_frame_err: got %b expected 0", frame_err); end
        checks++; if (overrun !== 1'b0)    begin errors++; $display("[TB] FAIL rmid_overrun: got %b expected 0", overrun); end
        checks++; if (rx_busy !== 1'b0)    begin errors++; $display("[TB] FAIL rmid_rx_busy: got %b expected 0", rx_busy); end
        checks++; if (rx_data !== 8'h00)   begin errors++; $display("[TB] FAIL rmid_rx_data: got %h expected 00", rx_data); end
        rst = 1'b1;
        rx  = 1'b1;
        repeat (4) @(negedge clk);
        sendFrame(8'hFF, 1'b1, -1, -1);
        checks++; if (riseAt !== 155)      begin errors++; $display("[TB] FAIL rmid_ff_rise: got %0d expected 155", riseAt); end
        checks++; if (rx_data !== 8'hFF)   begin errors++; $display("[TB] FAIL rmid_ff_data: got %h expected ff", rx_data); end
        popOne();
        checks++; if (rx_valid !== 1'b0)   begin errors++; $display("[TB] FAIL rmid_ff_pop: got %b expected 0", rx_valid); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_full_pop();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uart_rx_fifo
